// File: rtl/rom_ctrl_sweep_reader.sv
// Sweeps every scrambled-ROM word, streams the hashed region to KMAC through a 2-entry FIFO
// and strobes the top words out as the expected digest. Optional: ROM_CTRL_SWEEP_DUAL_CNT_EN.
module rom_ctrl_sweep_reader #(
  parameter int Width          = 40,
  parameter int Depth          = 16,
  parameter int NumDigestWords = 4,
  localparam int Aw            = $clog2(Depth),
  localparam int IdxW          = (NumDigestWords > 1) ? $clog2(NumDigestWords) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             req_o,
  output logic [Aw-1:0]    rom_addr_o,
  output logic [Aw-1:0]    prince_addr_o,
  input  logic             rvalid_i,
  input  logic [Width-1:0] clr_rdata_i,
  output logic             hash_valid_o,
  input  logic             hash_ready_i,
  output logic [Width-1:0] hash_data_o,
  output logic             hash_last_o,
  output logic             exp_valid_o,
  output logic [IdxW-1:0]  exp_idx_o,
  output logic [Width-1:0] exp_data_o,
  output logic             done_o,
  output logic             alert_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SWEEP = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [Aw-1:0] LastAddr     = Aw'(Depth - 1);
  localparam logic [Aw-1:0] DigestBase   = Aw'(Depth - NumDigestWords);
  localparam logic [Aw-1:0] LastHashAddr = Aw'(Depth - NumDigestWords - 1);

  state_e           state_r, state_s;
  logic [Aw-1:0]    cnt_a_r;
  logic [Aw-1:0]    cnt_b_s;
  logic             inflight_r;
  logic [Aw-1:0]    resp_addr_r;
  logic [1:0]       fifo_cnt_r;
  logic [Width-1:0] data0_r, data1_r;
  logic             last0_r, last1_r;

  logic             hash_valid_s, pop_s, push_s, req_s;
  logic             resp_ok_s, is_digest_s, exp_valid_s;
  logic             overflow_s, mismatch_s, err_s;
  logic [1:0]       eff_cnt_s, occ_s;
  logic             push_last_s;

  // FIFO occupancy seen by the issue rule already discounts a beat leaving this cycle,
  // so a ready sink sustains one request per cycle.
  always_comb begin
    hash_valid_s = (fifo_cnt_r != 2'd0) && (state_r != ST_ERROR);
    pop_s        = hash_valid_s && hash_ready_i;
    eff_cnt_s    = fifo_cnt_r - {1'b0, pop_s};
    occ_s        = eff_cnt_s + {1'b0, inflight_r};
    req_s        = (state_r == ST_SWEEP) && (occ_s < 2'd2);
    resp_ok_s    = rvalid_i && inflight_r;
    is_digest_s  = (resp_addr_r >= DigestBase);
    push_s       = resp_ok_s && !is_digest_s && (state_r != ST_ERROR);
    exp_valid_s  = resp_ok_s && is_digest_s && (state_r != ST_ERROR);
    overflow_s   = push_s && (fifo_cnt_r == 2'd2) && !pop_s;
    push_last_s  = (resp_addr_r == LastHashAddr);
  end

`ifdef ROM_CTRL_SWEEP_DUAL_CNT_EN
  logic [Aw-1:0] cnt_b_r;

  // Independent keystream address counter, same update rule as the ROM index counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_b_r <= {Aw{1'b0}};
    end else if (req_s && (cnt_b_r != LastAddr)) begin
      cnt_b_r <= cnt_b_r + Aw'(1);
    end else begin
      cnt_b_r <= cnt_b_r;
    end
  end

  always_comb begin
    cnt_b_s    = cnt_b_r;
    mismatch_s = (cnt_a_r != cnt_b_r);
  end
`else
  always_comb begin
    cnt_b_s    = cnt_a_r;
    mismatch_s = 1'b0;
  end
`endif

  // Protocol errors: stray response, missing response, FIFO overflow, counter divergence.
  always_comb begin
    err_s = (rvalid_i && !inflight_r) || (inflight_r && !rvalid_i) ||
            overflow_s || mismatch_s;
  end

  // Next-state logic; any error overrides the normal sequence.
  always_comb begin
    state_s = state_r;
    if (err_s) begin
      state_s = ST_ERROR;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) state_s = ST_SWEEP;
          else         state_s = ST_IDLE;
        end
        ST_SWEEP: begin
          if (req_s && (cnt_a_r == LastAddr)) state_s = ST_DRAIN;
          else                                state_s = ST_SWEEP;
        end
        ST_DRAIN: begin
          if (!inflight_r && (fifo_cnt_r == 2'd0)) state_s = ST_DONE;
          else                                     state_s = ST_DRAIN;
        end
        ST_DONE:  state_s = ST_DONE;
        ST_ERROR: state_s = ST_ERROR;
        default:  state_s = ST_ERROR;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // ROM index counter, saturating at the last word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_a_r <= {Aw{1'b0}};
    end else if (req_s && (cnt_a_r != LastAddr)) begin
      cnt_a_r <= cnt_a_r + Aw'(1);
    end else begin
      cnt_a_r <= cnt_a_r;
    end
  end

  // The ROM answers exactly one cycle later, so the request address tags the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_r  <= 1'b0;
      resp_addr_r <= {Aw{1'b0}};
    end else begin
      inflight_r  <= req_s;
      resp_addr_r <= req_s ? cnt_a_r : resp_addr_r;
    end
  end

  // Two-entry shift FIFO; entry 0 is always the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt_r <= 2'd0;
      data0_r    <= {Width{1'b0}};
      data1_r    <= {Width{1'b0}};
      last0_r    <= 1'b0;
      last1_r    <= 1'b0;
    end else if (push_s && pop_s) begin
      if (fifo_cnt_r == 2'd2) begin
        data0_r <= data1_r;
        last0_r <= last1_r;
        data1_r <= clr_rdata_i;
        last1_r <= push_last_s;
      end else begin
        data0_r <= clr_rdata_i;
        last0_r <= push_last_s;
      end
    end else if (push_s && !overflow_s) begin
      fifo_cnt_r <= fifo_cnt_r + 2'd1;
      if (fifo_cnt_r == 2'd0) begin
        data0_r <= clr_rdata_i;
        last0_r <= push_last_s;
      end else begin
        data1_r <= clr_rdata_i;
        last1_r <= push_last_s;
      end
    end else if (pop_s) begin
      fifo_cnt_r <= fifo_cnt_r - 2'd1;
      data0_r    <= data1_r;
      last0_r    <= last1_r;
    end else begin
      fifo_cnt_r <= fifo_cnt_r;
    end
  end

  // Digest words bypass the FIFO: the strobe has no backpressure.
  always_comb begin
    req_o         = req_s;
    rom_addr_o    = cnt_a_r;
    prince_addr_o = cnt_b_s;
    hash_valid_o  = hash_valid_s;
    hash_data_o   = data0_r;
    hash_last_o   = hash_valid_s && last0_r;
    exp_valid_o   = exp_valid_s;
    exp_idx_o     = exp_valid_s ? IdxW'(resp_addr_r - DigestBase) : {IdxW{1'b0}};
    exp_data_o    = exp_valid_s ? clr_rdata_i : {Width{1'b0}};
    done_o        = (state_r == ST_DONE);
    alert_o       = (state_r == ST_ERROR);
  end

endmodule

// File: tb/tb_rom_ctrl_sweep_reader.sv
// Directed bench for rom_ctrl_sweep_reader; a one-cycle ROM responder is folded into tick().
module tb_rom_ctrl_sweep_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        req_o;
  logic [3:0]  rom_addr_o, prince_addr_o;
  logic        rvalid_i = 1'b0;
  logic [39:0] clr_rdata_i = 40'h0;
  logic        hash_valid_o;
  logic        hash_ready_i = 1'b1;
  logic [39:0] hash_data_o;
  logic        hash_last_o;
  logic        exp_valid_o;
  logic [1:0]  exp_idx_o;
  logic [39:0] exp_data_o;
  logic        done_o, alert_o;

  rom_ctrl_sweep_reader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .req_o(req_o),
    .rom_addr_o(rom_addr_o), .prince_addr_o(prince_addr_o), .rvalid_i(rvalid_i),
    .clr_rdata_i(clr_rdata_i), .hash_valid_o(hash_valid_o), .hash_ready_i(hash_ready_i),
    .hash_data_o(hash_data_o), .hash_last_o(hash_last_o), .exp_valid_o(exp_valid_o),
    .exp_idx_o(exp_idx_o), .exp_data_o(exp_data_o), .done_o(done_o), .alert_o(alert_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc, first_req_cyc, last_req_cyc, first_hb_cyc, done_cyc, prince_bad;
  bit alert_seen;
  logic [3:0]  req_log[$];
  logic [39:0] hb_data[$];
  logic        hb_last[$];
  logic [1:0]  ex_idx[$];
  logic [39:0] ex_data[$];
  logic        s_req, s_hv, s_hl, s_alert, s_done;
  logic [3:0]  s_addr;
  logic [39:0] s_hd;

  function automatic logic [39:0] rom_word(input logic [3:0] a);
    return {24'hC0FFEE, 12'h000, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cyc = 0; first_req_cyc = -1; last_req_cyc = -1; first_hb_cyc = -1;
    done_cyc = -1; prince_bad = 0; alert_seen = 1'b0;
    req_log.delete(); hb_data.delete(); hb_last.delete();
    ex_idx.delete(); ex_data.delete();
  endtask

  // Sample at the falling edge, then answer the sampled request one cycle later.
  task automatic tick();
    @(negedge clk_i);
    s_req = req_o; s_addr = rom_addr_o; s_hv = hash_valid_o; s_hd = hash_data_o;
    s_hl = hash_last_o; s_alert = alert_o; s_done = done_o;
    if (s_req) begin
      req_log.push_back(s_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
      if (prince_addr_o !== rom_addr_o) prince_bad++;
    end
    if (s_hv && hash_ready_i) begin
      hb_data.push_back(s_hd);
      hb_last.push_back(s_hl);
      if (first_hb_cyc < 0) first_hb_cyc = cyc;
    end
    if (exp_valid_o) begin
      ex_idx.push_back(exp_idx_o);
      ex_data.push_back(exp_data_o);
    end
    if (s_done && done_cyc < 0) done_cyc = cyc;
    if (s_alert) alert_seen = 1'b1;
    @(posedge clk_i); #1;
    rvalid_i = s_req;
    clr_rdata_i = s_req ? rom_word(s_addr) : 40'h0;
    cyc++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; start_i = 1'b0; rvalid_i = 1'b0; clr_rdata_i = 40'h0;
    hash_ready_i = 1'b1; s_req = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic start_sweep();
    clear_logs();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  function automatic int seq_bad();
    int n = 0;
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] !== 4'(i)) n++;
    return n;
  endfunction

  function automatic int beats_bad();
    int n = 0;
    for (int i = 0; i < hb_data.size(); i++) begin
      if (hb_data[i] !== rom_word(4'(i))) n++;
      if (hb_last[i] !== (i == 11)) n++;
    end
    return n;
  endfunction

  function automatic int exp_bad();
    int n = 0;
    for (int i = 0; i < ex_idx.size(); i++) begin
      if (ex_idx[i] !== 2'(i)) n++;
      if (ex_data[i] !== rom_word(4'(12 + i))) n++;
    end
    return n;
  endfunction

  initial begin
    // Reset state
    do_reset();
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_addr", 64'({rom_addr_o, prince_addr_o}), 64'd0);
    chk("rst_hash", 64'({hash_valid_o, hash_last_o, hash_data_o}), 64'd0);
    chk("rst_exp", 64'({exp_valid_o, exp_idx_o, exp_data_o}), 64'd0);
    chk("rst_status", 64'({done_o, alert_o}), 64'd0);

    // Full sweep, sink always ready
    start_sweep();
    repeat (24) tick();
    chk("t1_nreq", 64'(req_log.size()), 64'd16);
    chk("t1_first_req", 64'(first_req_cyc), 64'd1);
    chk("t1_last_req", 64'(last_req_cyc), 64'd16);
    chk("t1_seq", 64'(seq_bad()), 64'd0);
    chk("t1_prince", 64'(prince_bad), 64'd0);
    chk("t1_first_beat", 64'(first_hb_cyc), 64'd3);
    chk("t1_nbeats", 64'(hb_data.size()), 64'd12);
    chk("t1_beats", 64'(beats_bad()), 64'd0);
    chk("t1_nexp", 64'(ex_idx.size()), 64'd4);
    chk("t1_exp", 64'(exp_bad()), 64'd0);
    chk("t1_done_by_20", 64'((done_cyc >= 0) && (done_cyc <= 20)), 64'd1);
    chk("t1_alert", 64'(alert_seen), 64'd0);
    chk("t1_req_after", 64'(s_req), 64'd0);

    // Backpressure from the start
    do_reset();
    hash_ready_i = 1'b0;
    start_sweep();
    repeat (7) tick();
    chk("t2_stall_nreq", 64'(req_log.size()), 64'd2);
    chk("t2_stall_seq", 64'(seq_bad()), 64'd0);
    chk("t2_held_valid", 64'(s_hv), 64'd1);
    chk("t2_held_data", 64'(s_hd), 64'(rom_word(4'd0)));
    hash_ready_i = 1'b1;
    repeat (25) tick();
    chk("t2_resume_addr", 64'((req_log.size() > 2) ? req_log[2] : 4'hF), 64'd2);
    chk("t2_nreq", 64'(req_log.size()), 64'd16);
    chk("t2_seq", 64'(seq_bad()), 64'd0);
    chk("t2_nbeats", 64'(hb_data.size()), 64'd12);
    chk("t2_beats", 64'(beats_bad()), 64'd0);
    chk("t2_done", 64'(s_done), 64'd1);
    chk("t2_alert", 64'(alert_seen), 64'd0);

    // Stray response in IDLE
    do_reset();
    clear_logs();
    rvalid_i = 1'b1;
    tick();
    chk("t3_alert_same", 64'(s_alert), 64'd0);
    tick();
    chk("t3_alert_next", 64'(s_alert), 64'd1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    chk("t3_no_req", 64'(req_log.size()), 64'd0);
    chk("t3_no_done", 64'(done_cyc < 0), 64'd1);
    chk("t3_alert_sticky", 64'(s_alert), 64'd1);

    // Asynchronous reset mid-sweep
    do_reset();
    start_sweep();
    for (int i = 0; i < 20; i++) if (rom_addr_o != 4'd7) tick();
    chk("t4_at7", 64'(rom_addr_o), 64'd7);
    rst_ni = 1'b0;
    #1;
    chk("t4_rst_req", 64'({req_o, rom_addr_o, prince_addr_o}), 64'd0);
    chk("t4_rst_hash", 64'({hash_valid_o, hash_last_o, hash_data_o}), 64'd0);
    chk("t4_rst_exp", 64'({exp_valid_o, exp_idx_o, exp_data_o}), 64'd0);
    chk("t4_rst_status", 64'({done_o, alert_o}), 64'd0);
    rvalid_i = 1'b0; clr_rdata_i = 40'h0; s_req = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    start_sweep();
    repeat (24) tick();
    chk("t4_nreq", 64'(req_log.size()), 64'd16);
    chk("t4_restart_seq", 64'(seq_bad()), 64'd0);
    chk("t4_beats", 64'(beats_bad()), 64'd0);
    chk("t4_done", 64'({s_done, alert_seen}), 64'd2);

    // start_i during SWEEP is ignored
    do_reset();
    start_sweep();
    for (int i = 0; i < 20; i++) if (rom_addr_o != 4'd5) tick();
    chk("t5_at5", 64'(rom_addr_o), 64'd5);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (24) tick();
    chk("t5_nreq", 64'(req_log.size()), 64'd16);
    chk("t5_seq", 64'(seq_bad()), 64'd0);
    chk("t5_done", 64'({s_done, alert_seen}), 64'd2);

`ifdef ROM_CTRL_SWEEP_DUAL_CNT_EN
    // Counter divergence
    do_reset();
    start_sweep();
    for (int i = 0; i < 20; i++) if (rom_addr_o != 4'd4) tick();
    chk("t6_at4", 64'(rom_addr_o), 64'd4);
    force dut.cnt_b_r = 4'd3;
    tick();
    chk("t6_alert_same", 64'(s_alert), 64'd0);
    release dut.cnt_b_r;
    tick();
    chk("t6_alert_next", 64'({s_alert, s_req}), 64'd2);
    clear_logs();
    repeat (5) tick();
    chk("t6_no_req", 64'(req_log.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
